// File: rtl/audio_adc_receiver.sv
// I2S / left-justified ADC line-in receiver: deserializes BCLK-framed serial data into
// 24-bit stereo frames and presents them on a valid/ready output register with overrun flag.
module audio_adc_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter bit I2S_DELAY  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  BCLK,
    input  logic                  ADC_LR_CLK,
    input  logic                  ADC_DATA,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } state_t;

    // Pin order inside the synchronizer bank: {BCLK, ADC_LR_CLK, ADC_DATA}
    logic [2:0] pins;
    logic [2:0] pins_sync;
    assign pins = {BCLK, ADC_LR_CLK, ADC_DATA};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic meta_q;
        logic sync_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
            end else begin
                meta_q <= pins[gi];
                sync_q <= meta_q;
            end
        end
        assign pins_sync[gi] = sync_q;
    end

    logic bclk_s, lr_s, data_s;
    assign bclk_s = pins_sync[2];
    assign lr_s   = pins_sync[1];
    assign data_s = pins_sync[0];

    logic bclk_dly_q;
    logic bclk_rise;
    assign bclk_rise = bclk_s & ~bclk_dly_q;

    state_t                state_q, state_d;
    logic                  ch_q, ch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  lr_prev_q, lr_prev_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
    logic                  left_seen_q, left_seen_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  lr_edge;
    logic                  commit;
    logic                  start_ch;
    logic [DATA_WIDTH-1:0] commit_word;
    logic [DATA_WIDTH-1:0] shifted_word;
    logic [CW-1:0]         bit_idx;
    logic                  load;

    assign lr_edge = lr_s ^ lr_prev_q;
    assign bit_idx = LAST - cnt_q;

    // Words fill MSB-first by index, so a short slot is already left-aligned with zero LSBs.
    always_comb begin
        shifted_word          = sr_q;
        shifted_word[bit_idx] = data_s;
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        lr_prev_d    = lr_prev_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        left_seen_d  = left_seen_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;
        start_ch     = 1'b0;
        commit_word  = '0;

        if (bclk_rise) begin
            lr_prev_d = lr_s;
            unique case (state_q)
                IDLE: begin
                    if (lr_edge && !lr_s) begin
                        start_ch    = 1'b1;
                        left_seen_d = 1'b0;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        // In I2S the LR-edge bit still carries the old channel's next bit.
                        commit      = 1'b1;
                        commit_word = I2S_DELAY ? shifted_word : sr_q;
                        start_ch    = 1'b1;
                    end else begin
                        sr_d  = shifted_word;
                        cnt_d = cnt_q + ONE;
                        if (cnt_q == LAST) begin
                            commit      = 1'b1;
                            commit_word = shifted_word;
                            state_d     = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lr_edge) begin
                        start_ch = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (commit) begin
                if (!ch_q) begin
                    left_hold_d = commit_word;
                    left_seen_d = 1'b1;
                end else if (left_seen_q) begin
                    right_hold_d = commit_word;
                    left_seen_d  = 1'b0;
                    frame_done_d = 1'b1;
                end
            end

            // I2S: the edge bit is the one-bit delay, MSB follows on the next rise.
            // Left-justified: the edge bit is the MSB itself.
            if (start_ch) begin
                ch_d    = lr_s;
                state_d = SHIFT;
                sr_d    = '0;
                cnt_d   = '0;
                if (!I2S_DELAY) begin
                    sr_d[DATA_WIDTH-1] = data_s;
                    cnt_d              = ONE;
                end
            end
        end
    end

    always_comb begin
        load      = frame_done_q && (!valid_q || ready);
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            left_d  = left_hold_q;
            right_d = right_hold_q;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (frame_done_q && !load) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_dly_q   <= 1'b0;
            state_q      <= IDLE;
            ch_q         <= 1'b0;
            cnt_q        <= '0;
            sr_q         <= '0;
            lr_prev_q    <= 1'b0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            left_seen_q  <= 1'b0;
            frame_done_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bclk_dly_q   <= bclk_s;
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            lr_prev_q    <= lr_prev_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            left_seen_q  <= left_seen_d;
            frame_done_q <= frame_done_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign left_out  = left_q;
    assign right_out = right_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;

endmodule
